// File: rtl/cpld_link_pkg.sv
// -----------------------------------------------------------------------------
// cpld_link_pkg
// Shared definitions for the serial frame link receiver:
//   DATA_SIZE_DEFAULT - payload bits per frame
//   TAG_A / TAG_B     - the two legal tag codes in the payload's top two bits
//   rx_state_t        - receiver FSM states
//   tag_is_valid()    - tag legality check used by the receiver
// -----------------------------------------------------------------------------
package cpld_link_pkg;

    localparam int DATA_SIZE_DEFAULT = 194;

    localparam logic [1:0] TAG_A = 2'b01;
    localparam logic [1:0] TAG_B = 2'b10;

    // WAIT_GAP : after reset, ignore the link until an inter-frame gap is seen
    // GAP      : between frames, waiting for the frame strobe to go high
    // SHIFT    : frame strobe high, collecting payload bits
    typedef enum logic [1:0] {
        ST_WAIT_GAP = 2'd0,
        ST_GAP      = 2'd1,
        ST_SHIFT    = 2'd2
    } rx_state_t;

    function automatic logic tag_is_valid(input logic [1:0] tag);
        return (tag == TAG_A) || (tag == TAG_B);
    endfunction

endpackage

// File: rtl/link_sync.sv
// -----------------------------------------------------------------------------
// link_sync
// Three-flop chain for one asynchronous link input. Stages 1-2 form the
// metastability synchronizer; stage 3 only exists to detect a rising edge.
// Every link input uses the same depth, so the data and strobe samples taken
// from stage 2 line up exactly with the detected link clock edge.
// Ports:
//   clk  - system clock
//   srst - synchronous active-high reset, clears all stages
//   din  - asynchronous link input
//   sync - synchronized level (stage 2)
//   rise - one-cycle pulse: stage 2 = 1 while stage 3 = 0
// -----------------------------------------------------------------------------
module link_sync (
    input  logic clk,
    input  logic srst,
    input  logic din,
    output logic sync,
    output logic rise
);

    // stage_reg[0] = stage 1, [1] = stage 2, [2] = stage 3
    logic [2:0] stage_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            stage_reg <= '0;
        end else begin
            stage_reg <= {stage_reg[1:0], din};
        end
    end

    assign sync = stage_reg[1];
    assign rise = stage_reg[1] & ~stage_reg[2];

endmodule

// File: rtl/ser_frame_rx.sv
// -----------------------------------------------------------------------------
// ser_frame_rx
// Receives fixed-length frames from a source-clocked serial link (bit clock,
// frame strobe, LSB-first data), all asynchronous to CLK. The first high slot
// of each frame is a dummy; the following DATA_SIZE bits form the payload.
// Good frames (exact length, legal tag) are presented on a valid/ready port.
// Ports:
//   CLK          - system clock, all logic on rising edge
//   RESET        - synchronous active-high reset
//   CLK_IN       - link bit clock (asynchronous)
//   DFRM_IN      - link frame strobe, high during a frame
//   SER_DATA_IN  - link serial data, LSB first
//   FRM_DATA     - received payload, stable while FRM_VALID
//   FRM_TAG      - payload bits [DATA_SIZE-1:DATA_SIZE-2]
//   FRM_VALID    - payload available
//   FRM_READY    - consumer accepts when FRM_VALID & FRM_READY
//   LEN_ERR      - one-cycle pulse: frame had the wrong bit count
//   TAG_ERR      - one-cycle pulse: good length but illegal tag
//   OVF_ERR      - one-cycle pulse: good frame dropped, output still held
//   FRM_CNT      - count of loaded good frames, wraps at 16 bits
// -----------------------------------------------------------------------------
module ser_frame_rx
    import cpld_link_pkg::*;
#(
    parameter int DATA_SIZE = DATA_SIZE_DEFAULT
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 CLK_IN,
    input  logic                 DFRM_IN,
    input  logic                 SER_DATA_IN,
    output logic [DATA_SIZE-1:0] FRM_DATA,
    output logic [1:0]           FRM_TAG,
    output logic                 FRM_VALID,
    input  logic                 FRM_READY,
    output logic                 LEN_ERR,
    output logic                 OVF_ERR,
    output logic                 TAG_ERR,
    output logic [15:0]          FRM_CNT
);

    // Bit counter must hold DATA_SIZE+1 so an over-long frame stays
    // distinguishable from a good one.
    localparam int                CNT_W    = $clog2(DATA_SIZE + 2);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DATA_SIZE);
    localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(DATA_SIZE + 1);

    // ------------------------------------------------------------------
    // Link input synchronizers: index 0 = CLK_IN, 1 = DFRM_IN, 2 = data
    // ------------------------------------------------------------------
    logic [2:0] link_in;
    logic [2:0] link_sync_bus;
    logic [2:0] link_rise_bus;

    assign link_in = {SER_DATA_IN, DFRM_IN, CLK_IN};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sync
            link_sync u_link_sync (
                .clk  (CLK),
                .srst (RESET),
                .din  (link_in[gi]),
                .sync (link_sync_bus[gi]),
                .rise (link_rise_bus[gi])
            );
        end
    endgenerate

    logic link_edge;
    logic dfrm_s;
    logic data_s;

    assign link_edge = link_rise_bus[0];
    assign dfrm_s    = link_sync_bus[1];
    assign data_s    = link_sync_bus[2];

    // Strobe/data edges and the clock level are not needed downstream.
    logic unused_link;
    assign unused_link = ^{link_rise_bus[2:1], link_sync_bus[0]};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    rx_state_t            state_reg,   state_next;
    logic [DATA_SIZE-1:0] shift_reg,   shift_next;
    logic [CNT_W-1:0]     bit_cnt_reg, bit_cnt_next;

    logic [DATA_SIZE-1:0] data_reg,    data_next;
    logic [1:0]           tag_reg,     tag_next;
    logic                 valid_reg,   valid_next;
    logic                 len_err_reg, len_err_next;
    logic                 tag_err_reg, tag_err_next;
    logic                 ovf_err_reg, ovf_err_next;
    logic [15:0]          frm_cnt_reg, frm_cnt_next;

    // Decision terms, exposed for readability
    logic                 frame_end;
    logic                 accept;
    logic                 len_bad;
    logic                 tag_bad;
    logic                 frame_good;
    logic                 load;
    logic [1:0]           rx_tag;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg   <= ST_WAIT_GAP;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            data_reg    <= '0;
            tag_reg     <= '0;
            valid_reg   <= 1'b0;
            len_err_reg <= 1'b0;
            tag_err_reg <= 1'b0;
            ovf_err_reg <= 1'b0;
            frm_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            bit_cnt_reg <= bit_cnt_next;
            data_reg    <= data_next;
            tag_reg     <= tag_next;
            valid_reg   <= valid_next;
            len_err_reg <= len_err_next;
            tag_err_reg <= tag_err_next;
            ovf_err_reg <= ovf_err_next;
            frm_cnt_reg <= frm_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM: acts only in the CLK cycle of a detected link edge
    // ------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt_reg;
        frame_end    = 1'b0;

        if (link_edge) begin
            case (state_reg)
                ST_WAIT_GAP: begin
                    // Only a gap slot proves we are aligned to frame boundaries.
                    if (!dfrm_s) begin
                        state_next = ST_GAP;
                    end
                end
                ST_GAP: begin
                    // First high slot carries the dummy bit: not shifted in.
                    if (dfrm_s) begin
                        state_next   = ST_SHIFT;
                        bit_cnt_next = '0;
                    end
                end
                ST_SHIFT: begin
                    if (dfrm_s) begin
                        // LSB-first link: new bits enter at the top and the
                        // first payload bit ends up in bit 0.
                        shift_next = {data_s, shift_reg[DATA_SIZE-1:1]};
                        if (bit_cnt_reg != CNT_SAT) begin
                            bit_cnt_next = bit_cnt_reg + 1'b1;
                        end
                    end else begin
                        state_next = ST_GAP;
                        frame_end  = 1'b1;
                    end
                end
                default: begin
                    state_next = ST_WAIT_GAP;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Frame qualification and output handshake
    // ------------------------------------------------------------------
    always_comb begin
        rx_tag       = shift_reg[DATA_SIZE-1 -: 2];
        accept       = valid_reg & FRM_READY;

        // Priority LEN > TAG > OVF falls out of each term masking the next.
        len_bad      = frame_end && (bit_cnt_reg != CNT_FULL);
        tag_bad      = frame_end && !len_bad && !tag_is_valid(rx_tag);
        frame_good   = frame_end && !len_bad && tag_is_valid(rx_tag);

        // A consumer taking the held payload in this cycle frees the slot.
        load         = frame_good && (!valid_reg || accept);

        len_err_next = len_bad;
        tag_err_next = tag_bad;
        ovf_err_next = frame_good && valid_reg && !accept;

        data_next    = data_reg;
        tag_next     = tag_reg;
        frm_cnt_next = frm_cnt_reg;
        valid_next   = valid_reg & ~accept;

        if (load) begin
            data_next    = shift_reg;
            tag_next     = rx_tag;
            frm_cnt_next = frm_cnt_reg + 16'd1;
            valid_next   = 1'b1;
        end
    end

    assign FRM_DATA  = data_reg;
    assign FRM_TAG   = tag_reg;
    assign FRM_VALID = valid_reg;
    assign LEN_ERR   = len_err_reg;
    assign TAG_ERR   = tag_err_reg;
    assign OVF_ERR   = ovf_err_reg;
    assign FRM_CNT   = frm_cnt_reg;

endmodule

// File: tb/tb_ser_frame_rx.sv
// -----------------------------------------------------------------------------
// tb_ser_frame_rx
// Directed bench for ser_frame_rx: drives the asynchronous link with a
// behavioural transmitter and checks the payload port, error pulses and
// frame counter against payloads built by the bench.
// -----------------------------------------------------------------------------
module tb_ser_frame_rx;

    localparam int DS = 194;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          CLK_IN;
    logic          DFRM_IN;
    logic          SER_DATA_IN;
    logic [DS-1:0] FRM_DATA;
    logic [1:0]    FRM_TAG;
    logic          FRM_VALID;
    logic          FRM_READY;
    logic          LEN_ERR;
    logic          OVF_ERR;
    logic          TAG_ERR;
    logic [15:0]   FRM_CNT;

    int tests_run    = 0;
    int tests_failed = 0;

    int len_pulses = 0;
    int tag_pulses = 0;
    int ovf_pulses = 0;
    int frames_sent = 0;

    logic [DS-1:0] got_q[$];

    always #5 CLK = ~CLK;

    ser_frame_rx #(.DATA_SIZE(DS)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .CLK_IN      (CLK_IN),
        .DFRM_IN     (DFRM_IN),
        .SER_DATA_IN (SER_DATA_IN),
        .FRM_DATA    (FRM_DATA),
        .FRM_TAG     (FRM_TAG),
        .FRM_VALID   (FRM_VALID),
        .FRM_READY   (FRM_READY),
        .LEN_ERR     (LEN_ERR),
        .OVF_ERR     (OVF_ERR),
        .TAG_ERR     (TAG_ERR),
        .FRM_CNT     (FRM_CNT)
    );

    // Pulse counters (count high cycles, so a wide pulse shows as >1) and
    // capture of every accepted payload.
    always @(negedge CLK) begin
        if (LEN_ERR) len_pulses <= len_pulses + 1;
        if (TAG_ERR) tag_pulses <= tag_pulses + 1;
        if (OVF_ERR) ovf_pulses <= ovf_pulses + 1;
        if (FRM_VALID && FRM_READY) got_q.push_back(FRM_DATA);
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------
    // Link transmitter helpers
    // ---------------------------------------------------------------
    task automatic link_slot(input logic d, input logic b, input int half);
        DFRM_IN     = d;
        SER_DATA_IN = b;
        #(half);
        CLK_IN = 1'b1;
        #(half);
        CLK_IN = 1'b0;
    endtask

    // Random phase relative to CLK, never landing on a rising CLK edge.
    task automatic align_phase();
        int ph;
        ph = $urandom_range(1, 9);
        @(posedge CLK);
        #(ph);
    endtask

    // nhigh high slots (slot 0 is the dummy, sent as 1) then a 2-slot gap.
    task automatic send_frame(input int nhigh, input logic [DS-1:0] p, input int half);
        logic b;
        align_phase();
        for (int i = 0; i < nhigh; i++) begin
            if (i == 0) b = 1'b1;
            else if (i - 1 < DS) b = p[i-1];
            else b = 1'b0;
            link_slot(1'b1, b, half);
        end
        link_slot(1'b0, 1'b0, half);
        link_slot(1'b0, 1'b0, half);
        frames_sent++;
        $display("[TB] frame %0d: %0d high slots, tag=%b, low byte=%h", frames_sent, nhigh, p[DS-1 -: 2], p[7:0]);
    endtask

    function automatic logic [DS-1:0] mk_payload(input logic [1:0] tag, input logic [7:0] low, input logic [31:0] pat);
        logic [223:0] w;
        logic [DS-1:0] p;
        w = {7{pat}};
        p = w[DS-1:0];
        p[7:0] = low;
        p[DS-1 -: 2] = tag;
        return p;
    endfunction

    function automatic logic [DS-1:0] rand_payload();
        logic [223:0] w;
        logic [DS-1:0] p;
        for (int k = 0; k < 7; k++) w[k*32 +: 32] = $urandom;
        p = w[DS-1:0];
        p[DS-1 -: 2] = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
        return p;
    endfunction

    task automatic wait_valid(output logic seen);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge CLK);
            if (FRM_VALID) seen = 1'b1;
        end
    endtask

    task automatic settle();
        repeat (6) @(negedge CLK);
    endtask

    // One-cycle accept, then confirm FRM_VALID dropped one CLK later.
    task automatic accept_one(input string name);
        @(negedge CLK);
        FRM_READY = 1'b1;
        @(negedge CLK);
        FRM_READY = 1'b0;
        tests_run++;
        if (FRM_VALID !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_valid_drop: got %b want 0", name, FRM_VALID);
        end
    endtask

    // ---------------------------------------------------------------
    // Tests
    // ---------------------------------------------------------------
    task automatic test_reset();
        @(negedge CLK);
        tests_run++;
        if (FRM_VALID !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", FRM_VALID); end
        tests_run++;
        if (FRM_DATA !== '0) begin tests_failed++; $display("FAIL reset_data: got %h want 0", FRM_DATA); end
        tests_run++;
        if (FRM_TAG !== 2'b00) begin tests_failed++; $display("FAIL reset_tag: got %b want 00", FRM_TAG); end
        tests_run++;
        if (FRM_CNT !== 16'd0) begin tests_failed++; $display("FAIL reset_cnt: got %0d want 0", FRM_CNT); end
        tests_run++;
        if ({LEN_ERR, TAG_ERR, OVF_ERR} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_errs: got %b want 000", {LEN_ERR, TAG_ERR, OVF_ERR});
        end
    endtask

    task automatic test_good_frame();
        logic [DS-1:0] p;
        logic seen;
        p = mk_payload(2'b01, 8'h5C, 32'hA5C3_0F96);
        link_slot(1'b0, 1'b0, 20);
        link_slot(1'b0, 1'b0, 20);
        send_frame(DS + 1, p, 20);
        wait_valid(seen);
        tests_run++;
        if (seen !== 1'b1) begin tests_failed++; $display("FAIL good_valid: got %b want 1", seen); end
        tests_run++;
        if (FRM_TAG !== 2'b01) begin tests_failed++; $display("FAIL good_tag: got %b want 01", FRM_TAG); end
        tests_run++;
        if (FRM_DATA[7:0] !== 8'h5C) begin tests_failed++; $display("FAIL good_low_byte: got %h want 5c", FRM_DATA[7:0]); end
        tests_run++;
        if (FRM_DATA !== p) begin tests_failed++; $display("FAIL good_data: got %h want %h", FRM_DATA, p); end
        tests_run++;
        if (FRM_CNT !== 16'd1) begin tests_failed++; $display("FAIL good_cnt: got %0d want 1", FRM_CNT); end
        tests_run++;
        if (len_pulses + tag_pulses + ovf_pulses !== 0) begin
            tests_failed++;
            $display("FAIL good_no_err: got %0d pulses want 0", len_pulses + tag_pulses + ovf_pulses);
        end
        accept_one("good");
    endtask

    task automatic test_len_err();
        int lens[3] = '{100, DS, DS + 2};
        int len0, cnt0;
        logic [DS-1:0] p;
        logic seen;
        foreach (lens[k]) begin
            len0 = len_pulses;
            cnt0 = int'(FRM_CNT);
            send_frame(lens[k], mk_payload(2'b01, 8'h11, 32'h1234_5678), 20);
            settle();
            tests_run++;
            if (len_pulses - len0 !== 1) begin
                tests_failed++;
                $display("FAIL len_err_%0d: got %0d pulse cycles want 1", lens[k], len_pulses - len0);
            end
            tests_run++;
            if (FRM_VALID !== 1'b0 || int'(FRM_CNT) !== cnt0) begin
                tests_failed++;
                $display("FAIL len_drop_%0d: got valid=%b cnt=%0d want valid=0 cnt=%0d", lens[k], FRM_VALID, FRM_CNT, cnt0);
            end
        end
        tests_run++;
        if (tag_pulses + ovf_pulses !== 0) begin
            tests_failed++;
            $display("FAIL len_exclusive: got %0d tag/ovf pulses want 0", tag_pulses + ovf_pulses);
        end
        p = mk_payload(2'b10, 8'hE7, 32'h0BAD_F00D);
        send_frame(DS + 1, p, 20);
        wait_valid(seen);
        tests_run++;
        if (seen !== 1'b1 || FRM_DATA !== p || FRM_TAG !== 2'b10) begin
            tests_failed++;
            $display("FAIL len_recover: got valid=%b tag=%b data=%h want 1 10 %h", seen, FRM_TAG, FRM_DATA, p);
        end
        tests_run++;
        if (FRM_CNT !== 16'd2) begin tests_failed++; $display("FAIL len_recover_cnt: got %0d want 2", FRM_CNT); end
        accept_one("len");
    endtask

    task automatic test_tag_err();
        logic [1:0] tags[2] = '{2'b11, 2'b00};
        int tag0, len0;
        foreach (tags[k]) begin
            tag0 = tag_pulses;
            len0 = len_pulses;
            send_frame(DS + 1, mk_payload(tags[k], 8'h3A, 32'hCAFE_BABE), 20);
            settle();
            tests_run++;
            if (tag_pulses - tag0 !== 1 || len_pulses !== len0) begin
                tests_failed++;
                $display("FAIL tag_err_%b: got tag pulses %0d len pulses %0d want 1 0", tags[k], tag_pulses - tag0, len_pulses - len0);
            end
            tests_run++;
            if (FRM_CNT !== 16'd2 || FRM_VALID !== 1'b0) begin
                tests_failed++;
                $display("FAIL tag_drop_%b: got cnt=%0d valid=%b want 2 0", tags[k], FRM_CNT, FRM_VALID);
            end
        end
    endtask

    task automatic test_overflow();
        logic [DS-1:0] pa, pb;
        logic seen;
        int ovf0;
        FRM_READY = 1'b0;
        ovf0 = ovf_pulses;
        pa = mk_payload(2'b01, 8'hA1, 32'h5555_AAAA);
        pb = mk_payload(2'b10, 8'hB2, 32'h3C3C_C3C3);
        send_frame(DS + 1, pa, 20);
        wait_valid(seen);
        send_frame(DS + 1, pb, 20);
        settle();
        tests_run++;
        if (ovf_pulses - ovf0 !== 1) begin
            tests_failed++;
            $display("FAIL ovf_pulse: got %0d pulse cycles want 1", ovf_pulses - ovf0);
        end
        tests_run++;
        if (FRM_VALID !== 1'b1 || FRM_DATA !== pa || FRM_TAG !== 2'b01) begin
            tests_failed++;
            $display("FAIL ovf_hold: got valid=%b tag=%b data=%h want 1 01 %h", FRM_VALID, FRM_TAG, FRM_DATA, pa);
        end
        tests_run++;
        if (FRM_CNT !== 16'd3) begin tests_failed++; $display("FAIL ovf_cnt: got %0d want 3", FRM_CNT); end
        accept_one("ovf");
    endtask

    task automatic test_reset_mid_frame();
        logic [DS-1:0] p;
        logic seen;
        int errs0;
        errs0 = len_pulses + tag_pulses + ovf_pulses;
        p = mk_payload(2'b01, 8'h77, 32'hDEAD_BEEF);
        align_phase();
        for (int i = 0; i < DS + 1; i++) begin
            link_slot(1'b1, (i == 0) ? 1'b1 : p[(i == 0) ? 0 : i - 1], 20);
            if (i == 80) begin
                @(negedge CLK);
                RESET = 1'b1;
                repeat (3) @(negedge CLK);
                RESET = 1'b0;
            end
        end
        link_slot(1'b0, 1'b0, 20);
        link_slot(1'b0, 1'b0, 20);
        settle();
        tests_run++;
        if (FRM_VALID !== 1'b0 || FRM_CNT !== 16'd0) begin
            tests_failed++;
            $display("FAIL rst_mid_out: got valid=%b cnt=%0d want 0 0", FRM_VALID, FRM_CNT);
        end
        tests_run++;
        if (len_pulses + tag_pulses + ovf_pulses !== errs0) begin
            tests_failed++;
            $display("FAIL rst_mid_err: got %0d new pulses want 0", len_pulses + tag_pulses + ovf_pulses - errs0);
        end
        p = mk_payload(2'b10, 8'h5A, 32'h0F0F_1234);
        send_frame(DS + 1, p, 20);
        wait_valid(seen);
        tests_run++;
        if (seen !== 1'b1 || FRM_DATA !== p || FRM_CNT !== 16'd1) begin
            tests_failed++;
            $display("FAIL rst_mid_recover: got valid=%b cnt=%0d data=%h want 1 1 %h", seen, FRM_CNT, FRM_DATA, p);
        end
        accept_one("rst_mid");
    endtask

    task automatic test_stream(input int half, input int n);
        logic [DS-1:0] exp_q[$];
        logic [DS-1:0] p;
        int errs0, cnt0;
        errs0 = len_pulses + tag_pulses + ovf_pulses;
        cnt0 = int'(FRM_CNT);
        got_q.delete();
        FRM_READY = 1'b1;
        for (int f = 0; f < n; f++) begin
            p = rand_payload();
            exp_q.push_back(p);
            send_frame(DS + 1, p, half);
        end
        settle();
        FRM_READY = 1'b0;
        tests_run++;
        if (got_q.size() !== n) begin
            tests_failed++;
            $display("FAIL stream_%0d_count: got %0d frames want %0d", half, got_q.size(), n);
        end
        for (int f = 0; f < n && f < got_q.size(); f++) begin
            tests_run++;
            if (got_q[f] !== exp_q[f]) begin
                tests_failed++;
                $display("FAIL stream_%0d_data[%0d]: got %h want %h", half, f, got_q[f], exp_q[f]);
            end
        end
        tests_run++;
        if (len_pulses + tag_pulses + ovf_pulses !== errs0) begin
            tests_failed++;
            $display("FAIL stream_%0d_err: got %0d pulses want 0", half, len_pulses + tag_pulses + ovf_pulses - errs0);
        end
        tests_run++;
        if (FRM_CNT !== 16'(cnt0 + n)) begin
            tests_failed++;
            $display("FAIL stream_%0d_cnt: got %0d want %0d", half, FRM_CNT, cnt0 + n);
        end
    endtask

    initial begin
        RESET       = 1'b1;
        CLK_IN      = 1'b0;
        DFRM_IN     = 1'b0;
        SER_DATA_IN = 1'b0;
        FRM_READY   = 1'b0;
        repeat (5) @(negedge CLK);
        test_reset();
        RESET = 1'b0;
        test_good_frame();
        test_len_err();
        test_tag_err();
        test_overflow();
        test_reset_mid_frame();
        test_stream(20, 30);
        test_stream(30, 15);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
